// File: rtl/led7_scan_driver_pkg.sv
// Shared constants and helpers for the 7-segment scan driver slice.
package led7_scan_driver_pkg;

  // Width of one displayed digit (BCD or hex nibble).
  localparam int NIBBLE_W = 4;

  // All-ones anode pattern; slice off the low NUM_DIGITS bits for "every digit dark".
  localparam logic [31:0] ANODE_OFF = '1;

  // Blink half-period phase: visible digits light, hidden digits with blink set go dark.
  typedef enum logic {
    PHASE_VISIBLE = 1'b0,
    PHASE_HIDDEN  = 1'b1
  } blink_phase_t;

  // Counter width for a modulo-n count; never narrower than one bit.
  function automatic int calc_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led7_scan_driver_if.sv
// Digit-data and decoder/anode signals between the display producer and the scan driver.
interface led7_scan_driver_if
  import led7_scan_driver_pkg::*;
#(
  parameter int NUM_DIGITS = 4
);

  logic [NIBBLE_W*NUM_DIGITS-1:0] i_digits;
  logic [NUM_DIGITS-1:0]          i_digit_en;
  logic [NUM_DIGITS-1:0]          i_blink;
  logic                           i_update;
  logic [NIBBLE_W-1:0]            o_binary;
  logic                           o_en;
  logic [NUM_DIGITS-1:0]          o_anode;
  logic                           o_frame_start;

  modport master (
    output i_digits, i_digit_en, i_blink, i_update,
    input  o_binary, o_en, o_anode, o_frame_start
  );

  modport slave (
    input  i_digits, i_digit_en, i_blink, i_update,
    output o_binary, o_en, o_anode, o_frame_start
  );

endinterface

// File: rtl/led7_scan_driver_mod_counter.sv
// Modulo-N counter with enable. Exposes the value it will hold after the next
// edge so callers can register outputs without an extra cycle of latency.
module mod_counter
  import led7_scan_driver_pkg::*;
#(
  parameter int N = 4,
  parameter int W = calc_width(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count_next,
  output logic         tc
);

  logic [W-1:0] count;

  assign tc = (count == W'(N - 1));

  // Advance when enabled, wrapping to zero from the terminal count.
  always_comb begin
    count_next = count;
    if (en) begin
      count_next = tc ? '0 : count + W'(1);
    end
  end

  // Hold the current count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/led7_scan_driver.sv
// Time-multiplexed scan controller feeding led7_decoder: one digit per slot,
// dead-time at the start of each slot, per-digit enable and blink, and digit
// data double-buffered so it only changes on a frame boundary.
module led7_scan_driver
  import led7_scan_driver_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int BLINK_FRAMES = 250
) (
  input logic               i_clk,
  input logic               i_rst_n,
  led7_scan_driver_if.slave bus
);

  localparam int SLOT_W   = calc_width(REFRESH_DIV);
  localparam int IDX_W    = calc_width(NUM_DIGITS);
  localparam int FRAME_W  = calc_width(BLINK_FRAMES);
  localparam int DIGITS_W = NIBBLE_W * NUM_DIGITS;
  localparam logic [NUM_DIGITS-1:0] ALL_OFF = ANODE_OFF[NUM_DIGITS-1:0];

  logic [SLOT_W-1:0]     slot_next;
  logic                  slot_tc;
  logic [IDX_W-1:0]      idx_next;
  logic                  idx_tc;
  logic [FRAME_W-1:0]    frame_next_unused;
  logic                  frame_tc;
  logic                  boundary;

  logic [DIGITS_W-1:0]   shadow_digits;
  logic [NUM_DIGITS-1:0] shadow_en;
  logic [NUM_DIGITS-1:0] shadow_blink;
  logic                  pending;
  blink_phase_t          blink_phase;

  logic                  capture;
  logic [DIGITS_W-1:0]   digits_next;
  logic [NUM_DIGITS-1:0] en_next;
  logic [NUM_DIGITS-1:0] blink_next;
  logic                  pending_next;
  blink_phase_t          phase_next;
  logic [NIBBLE_W-1:0]   nibble_next;
  logic                  lit_next;
  logic [NUM_DIGITS-1:0] anode_next;

  // Cycle position within the current digit slot.
  mod_counter #(.N(REFRESH_DIV), .W(SLOT_W)) u_slot (
    .clk(i_clk), .rst_n(i_rst_n), .en(1'b1),
    .count_next(slot_next), .tc(slot_tc)
  );

  // Which digit is being scanned; steps once per slot.
  mod_counter #(.N(NUM_DIGITS), .W(IDX_W)) u_index (
    .clk(i_clk), .rst_n(i_rst_n), .en(slot_tc),
    .count_next(idx_next), .tc(idx_tc)
  );

  assign boundary = slot_tc & idx_tc;

  // Frames elapsed in the current blink half-period; only its wrap matters.
  mod_counter #(.N(BLINK_FRAMES), .W(FRAME_W)) u_frame (
    .clk(i_clk), .rst_n(i_rst_n), .en(boundary),
    .count_next(frame_next_unused), .tc(frame_tc)
  );

  // Work out the state and output values that take effect on the coming edge.
  always_comb begin
    capture      = boundary & (pending | bus.i_update);
    digits_next  = capture ? bus.i_digits   : shadow_digits;
    en_next      = capture ? bus.i_digit_en : shadow_en;
    blink_next   = capture ? bus.i_blink    : shadow_blink;
    pending_next = ~boundary & (pending | bus.i_update);
    phase_next   = blink_phase;
    if (boundary && frame_tc) begin
      phase_next = (blink_phase == PHASE_VISIBLE) ? PHASE_HIDDEN : PHASE_VISIBLE;
    end
    nibble_next = '0;
    lit_next    = 1'b0;
    anode_next  = ALL_OFF;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_next == IDX_W'(k)) begin
        nibble_next = digits_next[k*NIBBLE_W +: NIBBLE_W];
        if ((slot_next >= SLOT_W'(BLANK_CYCLES)) && en_next[k] &&
            !(blink_next[k] && (phase_next == PHASE_HIDDEN))) begin
          lit_next      = 1'b1;
          anode_next[k] = 1'b0;
        end
      end
    end
  end

  // Register shadow data, handshake state and every output.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shadow_digits     <= '0;
      shadow_en         <= '0;
      shadow_blink      <= '0;
      pending           <= 1'b0;
      blink_phase       <= PHASE_VISIBLE;
      bus.o_binary      <= '0;
      bus.o_en          <= 1'b0;
      bus.o_anode       <= ALL_OFF;
      bus.o_frame_start <= 1'b0;
    end else begin
      shadow_digits     <= digits_next;
      shadow_en         <= en_next;
      shadow_blink      <= blink_next;
      pending           <= pending_next;
      blink_phase       <= phase_next;
      bus.o_binary      <= nibble_next;
      bus.o_en          <= lit_next;
      bus.o_anode       <= anode_next;
      bus.o_frame_start <= boundary;
    end
  end

endmodule

// File: tb/tb_led7_scan_driver.sv
// Self-checking bench for led7_scan_driver with a small scan geometry.
module tb_led7_scan_driver;

  localparam int ND    = 4;
  localparam int RD    = 8;
  localparam int BC    = 2;
  localparam int BF    = 2;
  localparam int FRAME = ND * RD;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  led7_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

  led7_scan_driver #(
    .NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC), .BLINK_FRAMES(BF)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus)
  );

  // Free-running clock, 10 ns period.
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit compare_on = 1'b0;
  int pos = 0;

  // Model state: cycles since reset release plus the digit data on display.
  int          m_k;
  logic [15:0] m_digits;
  logic [3:0]  m_en;
  logic [3:0]  m_blink;
  bit          m_pending;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Track elapsed cycles and latch new digit data whenever a frame begins.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_k       <= 0;
      m_digits  <= '0;
      m_en      <= '0;
      m_blink   <= '0;
      m_pending <= 1'b0;
    end else begin
      m_k <= m_k + 1;
      if ((m_k + 1) % FRAME == 0) begin
        if (m_pending || bus.i_update) begin
          m_digits <= bus.i_digits;
          m_en     <= bus.i_digit_en;
          m_blink  <= bus.i_blink;
        end
        m_pending <= 1'b0;
      end else if (bus.i_update) begin
        m_pending <= 1'b1;
      end
    end
  end

  // Derive the required outputs from elapsed time and the latched digit data.
  function automatic void model_outputs(output logic [3:0] bin, output logic en,
                                        output logic [3:0] an, output logic fs);
    int c;
    int idx;
    int f;
    bit hidden;
    bit vis;
    c      = m_k % RD;
    idx    = (m_k / RD) % ND;
    f      = m_k / FRAME;
    hidden = ((f / BF) % 2) == 1;
    vis    = (c >= BC) && m_en[idx] && !(m_blink[idx] && hidden);
    bin    = m_digits[idx*4 +: 4];
    en     = vis;
    an     = vis ? ~(4'b0001 << idx) : 4'b1111;
    fs     = (m_k > 0) && (m_k % FRAME == 0);
  endfunction

  // Compare every output against the model on each falling edge out of reset.
  always @(negedge clk) begin
    logic [3:0] eb;
    logic       ee;
    logic [3:0] ea;
    logic       ef;
    if (rst_n && compare_on) begin
      model_outputs(eb, ee, ea, ef);
      check_output("model_binary", 32'(bus.o_binary), 32'(eb));
      check_output("model_en", 32'(bus.o_en), 32'(ee));
      check_output("model_anode", 32'(bus.o_anode), 32'(ea));
      check_output("model_frame_start", 32'(bus.o_frame_start), 32'(ef));
    end
  end

  task automatic tick();
    @(negedge clk);
    pos = (pos + 1) % FRAME;
  endtask

  task automatic goto_pos(input int p);
    while (pos != p) tick();
  endtask

  task automatic wait_boundary();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.o_frame_start && n <= FRAME + 4);
    check_output("boundary_reached", 32'(bus.o_frame_start), 32'h1);
    pos = 0;
  endtask

  task automatic count_to_first_boundary(input string name);
    int n;
    n = 0;
    while (n < FRAME + 8) begin
      @(posedge clk);
      n++;
      #1;
      if (bus.o_frame_start) break;
    end
    check_output(name, 32'(n), 32'(FRAME));
    @(negedge clk);
    pos = 0;
  endtask

  task automatic apply_stimulus(input logic [15:0] digits, input logic [3:0] en,
                                input logic [3:0] blink, input bit upd);
    bus.i_digits   = digits;
    bus.i_digit_en = en;
    bus.i_blink    = blink;
    if (upd) begin
      bus.i_update = 1'b1;
      tick();
      bus.i_update = 1'b0;
    end
  endtask

  task automatic expect_slot(input string name, input logic [3:0] an,
                             input logic en, input logic [3:0] bin);
    check_output({name, "_anode"}, 32'(bus.o_anode), 32'(an));
    check_output({name, "_en"}, 32'(bus.o_en), 32'(en));
    check_output({name, "_binary"}, 32'(bus.o_binary), 32'(bin));
  endtask

  // Blink expectation for digit 0 over the four frames after capture.
  bit lit_table [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  // Directed test sequence.
  initial begin
    bus.i_digits   = '0;
    bus.i_digit_en = '0;
    bus.i_blink    = '0;
    bus.i_update   = 1'b0;

    // Reset held, then released; display stays dark until the first frame.
    #12;
    expect_slot("reset", 4'b1111, 1'b0, 4'h0);
    check_output("reset_frame_start", 32'(bus.o_frame_start), 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    compare_on = 1'b1;
    count_to_first_boundary("first_boundary_cycles");

    // All four digits enabled with 4321.
    tick();
    apply_stimulus(16'h4321, 4'b1111, 4'b0000, 1'b1);
    wait_boundary();
    check_output("t2_frame_start", 32'(bus.o_frame_start), 32'h1);
    expect_slot("t2_s0c0", 4'b1111, 1'b0, 4'h1);
    goto_pos(1);
    expect_slot("t2_s0c1", 4'b1111, 1'b0, 4'h1);
    goto_pos(2);
    expect_slot("t2_s0c2", 4'b1110, 1'b1, 4'h1);
    goto_pos(13);
    expect_slot("t2_s1c5", 4'b1101, 1'b1, 4'h2);
    goto_pos(19);
    expect_slot("t2_s2c3", 4'b1011, 1'b1, 4'h3);
    goto_pos(31);
    expect_slot("t2_s3c7", 4'b0111, 1'b1, 4'h4);

    // Digit 2 disabled.
    tick();
    apply_stimulus(16'h4321, 4'b1011, 4'b0000, 1'b1);
    wait_boundary();
    goto_pos(4);
    expect_slot("t3_s0", 4'b1110, 1'b1, 4'h1);
    goto_pos(12);
    expect_slot("t3_s1", 4'b1101, 1'b1, 4'h2);
    goto_pos(20);
    expect_slot("t3_s2", 4'b1111, 1'b0, 4'h3);
    goto_pos(28);
    expect_slot("t3_s3", 4'b0111, 1'b1, 4'h4);

    // Digit 0 blinks with a four-frame period; digit 1 stays lit.
    apply_stimulus(16'h4321, 4'b1111, 4'b0001, 1'b1);
    wait_boundary();
    for (int fi = 0; fi < 4; fi++) begin
      goto_pos(4);
      check_output("t4_blink_en", 32'(bus.o_en), 32'(lit_table[fi]));
      check_output("t4_blink_anode", 32'(bus.o_anode),
                   lit_table[fi] ? 32'h0000000e : 32'h0000000f);
      goto_pos(12);
      expect_slot("t4_digit1", 4'b1101, 1'b1, 4'h2);
      if (fi < 3) wait_boundary();
    end

    // Mid-frame update only takes effect on the next frame.
    goto_pos(13);
    apply_stimulus(16'h9999, 4'b1111, 4'b0000, 1'b1);
    goto_pos(20);
    expect_slot("t5_old_s2", 4'b1011, 1'b1, 4'h3);
    goto_pos(28);
    expect_slot("t5_old_s3", 4'b0111, 1'b1, 4'h4);
    wait_boundary();
    goto_pos(4);
    expect_slot("t5_new_s0", 4'b1110, 1'b1, 4'h9);
    goto_pos(28);
    expect_slot("t5_new_s3", 4'b0111, 1'b1, 4'h9);

    // Update raised in the boundary cycle itself lands in that slot 0.
    goto_pos(31);
    apply_stimulus(16'h5678, 4'b1111, 4'b0000, 1'b1);
    check_output("t5_same_cycle_fs", 32'(bus.o_frame_start), 32'h1);
    expect_slot("t5_same_cycle_s0", 4'b1111, 1'b0, 4'h8);
    goto_pos(10);
    expect_slot("t5_same_cycle_s1", 4'b1101, 1'b1, 4'h7);
    apply_stimulus(16'h1111, 4'b1111, 4'b0000, 1'b0);
    wait_boundary();
    goto_pos(2);
    expect_slot("t5_no_stale_capture", 4'b1110, 1'b1, 4'h8);

    // Asynchronous reset between edges in slot 1.
    goto_pos(13);
    #2 rst_n = 1'b0;
    #1;
    expect_slot("t6_async_reset", 4'b1111, 1'b0, 4'h0);
    check_output("t6_async_frame_start", 32'(bus.o_frame_start), 32'h0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    count_to_first_boundary("t6_boundary_cycles");
    expect_slot("t6_after_reset", 4'b1111, 1'b0, 4'h0);
    repeat (4) tick();

    compare_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete (t=%0t)", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/led7_scan_driver.md
Name: led7_scan_driver

Overview:
Time-multiplexed scan controller for the safelock's multi-digit 7-segment display. It sits directly upstream of led7_decoder and drives that decoder's i_binary and i_en inputs with one digit at a time. It also drives the shared active-low digit anodes, inserts dead-time between digits to prevent ghosting, and supports per-digit enable and blink. Digit data is double-buffered and applied only on frame boundaries.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (must be at least 1).
REFRESH_DIV, 100000, clock cycles per digit slot (must be at least 2).
BLANK_CYCLES, 1000, dead-time cycles at the start of each slot (must be less than REFRESH_DIV).
BLINK_FRAMES, 250, frames per blink half-period (must be at least 1).

Ports:
i_clk  in  1  system clock.
i_rst_n  in  1  asynchronous active-low reset.
i_digits  in  4*NUM_DIGITS  packed BCD/hex digits; digit k is in bits [4k+3:4k], and digit 0 is the rightmost.
i_digit_en  in  NUM_DIGITS  1 = digit k is displayed.
i_blink  in  NUM_DIGITS  1 = digit k blinks.
i_update  in  1  single-cycle request to capture the i_* digit inputs at the next frame boundary.
o_binary  out  4  nibble for led7_decoder i_binary.
o_en  out  1  enable for led7_decoder i_en.
o_anode  out  NUM_DIGITS  active-low digit select.
o_frame_start  out  1  one-cycle pulse on the first cycle of slot 0.

Behaviour:
- Single clock domain. Reset is asynchronous and active-low. All outputs are registers.
- Reset values:
  - o_binary=0, o_en=0, o_anode=all 1s, o_frame_start=0.
  - Shadow digits, enables and blink mask = 0.
  - pending=0, slot counter=0, digit index=0, frame counter=0, blink_phase=0 (visible).
- Slot counter:
  - Counts 0..REFRESH_DIV-1.
  - On wrap, index advances 0..NUM_DIGITS-1 and then back to 0.
- Outputs are registered from next-state, so they change on the same edge the counters enter the new value. There is no extra latency.
- Within the slot for index idx, with counter value c:
  - c < BLANK_CYCLES: o_anode=all 1s, o_en=0.
  - c >= BLANK_CYCLES: visible = shadow_en[idx] AND NOT (shadow_blink[idx] AND blink_phase).
    - If visible: o_anode bit idx = 0 (others 1), o_en=1.
    - Else: o_anode=all 1s, o_en=0.
  - o_binary = shadow digit idx for the whole slot, including dead-time.
- Frame boundary is the edge on which index goes NUM_DIGITS-1 to 0. On that edge:
  - o_frame_start=1 for that one cycle.
  - If pending=1 or i_update=1: shadows load from i_digits, i_digit_en and i_blink sampled that cycle, and pending clears.
  - Frame counter increments. When it wraps at BLINK_FRAMES-1, blink_phase toggles.
- i_update sets pending. Repeated pulses before a boundary cause a single capture.
- Inputs are sampled at the boundary, not at the i_update pulse, so the producer holds the inputs stable until o_frame_start.
- First boundary occurs NUM_DIGITS*REFRESH_DIV cycles after reset release. The display is blank until then.
- Asserting reset mid-slot forces the reset values immediately, without waiting for a clock edge.

Decomposition:
- Shared package holds:
  - ANODE_OFF (all-ones pattern) and the digit-nibble width constant 4.
  - $clog2-derived widths for the slot, index and frame counters.
- One sub-module, mod_counter: a parameterised modulo-N counter with enable and terminal-count output. It is instantiated for the slot counter, the digit index and the blink frame counter.

Test Plan:
(Bench parameters: NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, BLINK_FRAMES=2.)
1. Reset, then release: during reset o_anode=4'b1111, o_en=0, o_binary=0. After release, no anode goes low and o_frame_start first pulses at cycle 32.
2. i_digits=16'h4321, i_digit_en=4'b1111, i_blink=0, one i_update pulse, then next frame:
   - Slot 0: cycles 0-1 give anode 1111, en=0, binary=1; cycles 2-7 give anode 1110, en=1.
   - Slots 1/2/3: anode 1101/1011/0111, binary 2/3/4.
3. i_digit_en=4'b1011, then update: slot 2 shows anode 1111 and en=0 throughout with binary=3. Slots 0, 1 and 3 are unchanged.
4. i_blink=4'b0001: digit 0 is lit for 2 frames and dark for 2 frames, a 128-cycle period. Other digits stay lit.
5. Mid-frame i_digits=16'h9999 with i_update: rest of the current frame still shows 4321, and the next frame shows 9 on all digits. An i_update in the same cycle as the boundary is applied in that slot 0.
6. Assert i_rst_n=0 at slot 1 cycle 5 between clock edges: o_anode=1111 and o_en=0 immediately. After release, the first boundary is again 32 cycles later.
